lc4_divider_iter: RTL and testbench



---
 rtl/lc4_divider_iter.sv | 123 ++++++++++++
 tb/tb_lc4_divider_iter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/lc4_divider_iter.sv
// Iterative restoring unsigned divider for the LC4 execute stage (DIV/MOD).
// Resolves BITS_PER_CYCLE quotient bits per clock; results held until the next completion.
module lc4_divider_iter #(
   parameter int W              = 16,
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [W-1:0] dividend,
   input  logic [W-1:0] divisor,
   output logic         busy,
   output logic         valid,
   output logic [W-1:0] quotient,
   output logic [W-1:0] remainder,
   output logic [1:0]   state_o
);

   localparam int ITERS = W / BITS_PER_CYCLE;
   localparam int CW    = (ITERS > 1) ? $clog2(ITERS) : 1;

   // Handshake: start is taken on any rising edge where the state is IDLE or DONE
   // and ignored otherwise; valid is a one-cycle pulse with no backpressure.
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [W-1:0]  q_q, q_d;
   logic [W-1:0]  d_q, d_d;
   logic [W:0]    r_q, r_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [W-1:0]  quotient_q, quotient_d;
   logic [W-1:0]  remainder_q, remainder_d;

   logic [W:0]    r_t;
   logic [W-1:0]  q_t;
   logic          last;

   // R stays below D after each restore, so dropping R[W] on the shift loses nothing.
   always_comb begin
      r_t = r_q;
      q_t = q_q;
      for (int i = 0; i < BITS_PER_CYCLE; i++) begin
         r_t = {r_t[W-1:0], q_t[W-1]};
         q_t = {q_t[W-2:0], 1'b0};
         if (r_t >= {1'b0, d_q}) begin
            r_t    = r_t - {1'b0, d_q};
            q_t[0] = 1'b1;
         end
      end
   end

   assign last = (cnt_q == CW'(ITERS - 1));

   always_comb begin
      state_d     = state_q;
      q_d         = q_q;
      d_d         = d_q;
      r_d         = r_q;
      cnt_d       = cnt_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            state_d = S_IDLE;
            if (start) begin
               q_d     = dividend;
               d_d     = divisor;
               r_d     = '0;
               cnt_d   = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            q_d   = q_t;
            r_d   = r_t;
            cnt_d = cnt_q + 1'b1;
            if (last) begin
               state_d = S_DONE;
               // Divide by zero yields 0/0 to match LC4 DIV/MOD.
               if (d_q == '0) begin
                  quotient_d  = '0;
                  remainder_d = '0;
               end else begin
                  quotient_d  = q_t;
                  remainder_d = r_t[W-1:0];
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         q_q         <= '0;
         d_q         <= '0;
         r_q         <= '0;
         cnt_q       <= '0;
         quotient_q  <= '0;
         remainder_q <= '0;
      end else begin
         state_q     <= state_d;
         q_q         <= q_d;
         d_q         <= d_d;
         r_q         <= r_d;
         cnt_q       <= cnt_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
      end
   end

   assign busy      = (state_q == S_RUN);
   assign valid     = (state_q == S_DONE);
   assign quotient  = quotient_q;
   assign remainder = remainder_q;
   assign state_o   = state_q;

endmodule

// File: tb/tb_lc4_divider_iter.sv
// Scoreboard bench for lc4_divider_iter: driver pushes expected results, monitor pops on valid.
module tb_lc4_divider_iter;

   localparam int W     = 16;
   localparam int BPC   = 1;
   localparam int ITERS = W / BPC;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [W-1:0] dividend;
   logic [W-1:0] divisor;
   logic         busy;
   logic         valid;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic [1:0]   dbg_state;

   logic [2*W-1:0] exp_q[$];
   int             lat_q[$];
   int             errors = 0;
   int             checks = 0;
   int             cyc    = 0;

   lc4_divider_iter #(.W(W), .BITS_PER_CYCLE(BPC)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .dividend  (dividend),
      .divisor   (divisor),
      .busy      (busy),
      .valid     (valid),
      .quotient  (quotient),
      .remainder (remainder),
      .state_o   (dbg_state)
   );

   // clock/reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // driver tasks
   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eq, input logic [W-1:0] er);
      start    = 1'b1;
      dividend = a;
      divisor  = b;
      exp_q.push_back({eq, er});
      @(posedge clk);
      #1;
      lat_q.push_back(cyc + ITERS);
      start = 1'b0;
   endtask

   task automatic pulse_ignored(input logic [W-1:0] a, input logic [W-1:0] b);
      start    = 1'b1;
      dividend = a;
      divisor  = b;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_valid();
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < ITERS + 8 && !seen; i++) begin
         @(negedge clk);
         if (valid) seen = 1'b1;
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL valid_timeout: got no valid, required valid within %0d cycles", ITERS + 8);
      end
   endtask

   task automatic to_idle();
      @(posedge clk);
      #1;
   endtask

   // monitor: pops the scoreboard whenever the DUT presents valid
   task automatic monitor();
      int             brun;
      logic [2*W-1:0] prev;
      logic [2*W-1:0] e;
      int             le;
      brun = 0;
      prev = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            brun = 0;
            prev = {quotient, remainder};
         end else begin
            if (busy) brun++;
            if (valid) begin
               chk("busy_len", brun, ITERS);
               chk("busy_in_done", {31'd0, busy}, 32'd0);
               brun = 0;
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_valid: got q=%h r=%h, required no valid", quotient, remainder);
               end else begin
                  e  = exp_q.pop_front();
                  le = lat_q.pop_front();
                  chk("quotient", {16'd0, quotient}, {16'd0, e[2*W-1:W]});
                  chk("remainder", {16'd0, remainder}, {16'd0, e[W-1:0]});
                  chk("latency", cyc, le);
               end
            end else begin
               chk("result_hold", {quotient, remainder}, prev);
            end
            prev = {quotient, remainder};
         end
      end
   endtask

   logic [W-1:0] dv_a [8] = '{16'd100, 16'hFFFF, 16'h0005, 16'h1234, 16'hFFFF, 16'h8000, 16'd0,   16'd12345};
   logic [W-1:0] dv_b [8] = '{16'd7,   16'h0001, 16'hFFFF, 16'h0000, 16'hFFFF, 16'h00FF, 16'd5,   16'd123};
   logic [W-1:0] dv_q [8] = '{16'h000E, 16'hFFFF, 16'h0000, 16'h0000, 16'h0001, 16'h0080, 16'h0000, 16'h0064};
   logic [W-1:0] dv_r [8] = '{16'h0002, 16'h0000, 16'h0005, 16'h0000, 16'h0000, 16'h0080, 16'h0000, 16'h002D};

   initial begin
      logic [W-1:0] ra, rb;
      rst_n    = 1'b0;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
      fork
         monitor();
      join_none
      repeat (2) @(negedge clk);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_valid", {31'd0, valid}, 32'd0);
      chk("rst_quotient", {16'd0, quotient}, 32'd0);
      chk("rst_remainder", {16'd0, remainder}, 32'd0);
      rst_n = 1'b1;
      to_idle();

      for (int i = 0; i < 8; i++) begin
         issue(dv_a[i], dv_b[i], dv_q[i], dv_r[i]);
         wait_valid();
         to_idle();
      end

      // starts during RUN are ignored, then a back-to-back start in DONE
      issue(16'd50, 16'd5, 16'h000A, 16'h0000);
      repeat (2) @(posedge clk);
      #1;
      pulse_ignored(16'd9, 16'd3);
      repeat (6) @(posedge clk);
      #1;
      pulse_ignored(16'd9, 16'd3);
      wait_valid();
      issue(16'd9, 16'd3, 16'h0003, 16'h0000);
      wait_valid();
      to_idle();

      // asynchronous reset in the middle of an operation
      issue(16'd1000, 16'd3, 16'h014D, 16'h0001);
      repeat (7) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("arst_busy", {31'd0, busy}, 32'd0);
      chk("arst_valid", {31'd0, valid}, 32'd0);
      chk("arst_quotient", {16'd0, quotient}, 32'd0);
      chk("arst_remainder", {16'd0, remainder}, 32'd0);
      exp_q.delete();
      lat_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (ITERS + 6) @(posedge clk);
      #1;
      issue(16'd1000, 16'd3, 16'h014D, 16'h0001);
      wait_valid();
      to_idle();

      for (int i = 0; i < 40; i++) begin
         ra = 16'($urandom_range(0, 65535));
         rb = (i % 2 == 0) ? 16'($urandom_range(1, 15)) : 16'($urandom_range(1, 65535));
         issue(ra, rb, ra / rb, ra % rb);
         wait_valid();
         to_idle();
      end

      repeat (4) @(posedge clk);
      chk("pending", exp_q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
